alu_rs: RTL
===========

Name: alu_rs

Overview:
- Reservation station that feeds the ALU execute stage.
- Accepts dispatched ALU and branch micro-ops from the decoder/ROB.
- Holds each op until both operands are resolved, snooping the ALU and LSB CDB broadcasts to do so.
- Issues at most one ready op per cycle to the ALU through registered rs_* outputs.

Parameters:
- RS_SIZE, 16, number of entries; power of two, at least 2.
- ROB_IDX_W, 4, width of a ROB tag; tag 0 is reserved and means "no dependency / value ready".
- OPT_W, 6, width of the shared INST_OPT opcode encoding.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- rdy  in  1  global enable; 0 freezes all state.
- flush  in  1  mispredict rollback; discards every entry.
- disp_valid  in  1  dispatch request this cycle.
- disp_opt  in  OPT_W  opcode.
- disp_val1 / disp_val2  in  32  operand values, meaningful when the matching tag is 0.
- disp_q1 / disp_q2  in  ROB_IDX_W  producer tags; 0 means the operand is ready.
- disp_imm  in  32  immediate.
- disp_rob_idx  in  ROB_IDX_W  destination ROB tag.
- rs_full  out  1  high when no entry is free; combinational from registered state.
- cdb_alu_valid, cdb_alu_src[ROB_IDX_W], cdb_alu_val[32]  in  ALU broadcast.
- cdb_lsb_valid, cdb_lsb_src[ROB_IDX_W], cdb_lsb_val[32]  in  LSB broadcast.
- rs_valid  out  1  issued op valid (registered).
- rs_opt  out  OPT_W  issued opcode (registered).
- rs_val1 / rs_val2  out  32  issued operand values (registered).
- rs_imm  out  32  issued immediate (registered).
- rs_rob_idx  out  ROB_IDX_W  issued destination tag (registered).

Behaviour:
- Per-entry state: busy, opt, val1, q1, val2, q2, imm, rob_idx.

Reset
- rst==0 at an edge clears every busy bit and sets all rs_* outputs to 0.
- rs_full reads 0 after reset.
- Reset mid-operation discards all entries with no residue.

Priority per edge: reset > !rdy > flush > normal operation.

Stall
- rdy==0: no state changes; the rs_* outputs hold their values; dispatch is ignored.

Flush
- All busy bits clear and rs_valid goes to 0 at that edge.
- A dispatch presented in the same cycle is dropped.

Dispatch
- Accepted when disp_valid && !rs_full.
- Written into the lowest-index free entry.
- Dispatch while full is ignored; the upstream stage must hold the op.

Wakeup
- Each busy entry with qN!=0 that matches a valid CDB src with src!=0 captures the value and sets qN=0.
- A CDB value arriving in the same cycle as dispatch is bypassed into the new entry, so no broadcast is lost.
- If both CDBs match the same tag, the ALU bus wins. This should never happen.

Issue
- Candidates: busy entries with q1==0 && q2==0, as of the start of the cycle (registered state).
- The lowest index wins.
- At the edge: the winner's fields are copied into rs_*, rs_valid=1, and the winner's busy bit is cleared.
- With no candidate, rs_valid=0 and the other rs_* outputs keep their old values.

Latency
- An op dispatched with both operands ready at edge N drives rs_valid at edge N+1.
- An op woken by a CDB value at edge N issues at edge N+1 at the earliest.

Simultaneous events
- A slot freed by issue at edge N is only reusable by a dispatch at edge N+1.
- Dispatch and issue in the same cycle are allowed.
- rs_full reflects the post-edge occupancy.

Other rules
- Operand values are stored unmodified; no arithmetic is done in this block.
- There is no age ordering beyond lowest index. Starvation is acceptable because the ROB retires in order and stalls dispatch.

Decomposition:
- Shared package / utils header holds: WORD_TP, ROB_IDX_TP, INST_OPT_TP, the OPT_* encodings, TRUE/FALSE, ZERO_WORD, RS_SIZE.
- Natural sub-module: rs_prio_enc, a parameterised lowest-index-set priority encoder with outputs found and idx.
  - Instantiated twice: once for the free-slot search, once for the ready-op search.

Test Plan:
- Reset and idle: hold rst=0 for 2 cycles, then release with no dispatch → rs_valid=0, rs_full=0, all rs_* = 0.
- Ready op: dispatch ADD, val1=5, val2=7, q1=q2=0, rob_idx=3 at edge N → at edge N+1, rs_valid=1, rs_opt=ADD, rs_val1=5, rs_val2=7, rs_rob_idx=3; at N+2, rs_valid=0.
- Wakeup:
  - Dispatch BLT with q1=2 and val2=0; op does not issue.
  - Then cdb_alu_valid=1, src=2, val=0xFFFFFFFF at edge M.
  - → issued at M+1 with rs_val1=0xFFFFFFFF.
- Same-cycle bypass: dispatch with q2=5 while cdb_lsb_valid=1, src=5, val=0x1234 → issued the next edge with rs_val2=0x1234.
- Full and back-pressure:
  - Dispatch 16 ops, each with q1=9 → rs_full=1; a 17th dispatch is ignored.
  - Then broadcast tag 9 → 16 consecutive issues in index order, and rs_full drops after the first issue.
- Flush and stall:
  - Fill 4 entries, then hold rdy=0 for 3 cycles → outputs are frozen.
  - Then flush=1 together with disp_valid=1 → all entries are cleared, rs_valid=0, and nothing is issued afterwards.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared types, opcode encodings and sizing constants for the ALU reservation station.
package alu_rs_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned ROB_IDX_W = 4;
    localparam int unsigned OPT_W     = 6;
    localparam int unsigned RS_SIZE   = 16;

    typedef logic [WORD_W-1:0]    WORD_TP;
    typedef logic [ROB_IDX_W-1:0] ROB_IDX_TP;
    typedef logic [OPT_W-1:0]     INST_OPT_TP;

    localparam logic   TRUE      = 1'b1;
    localparam logic   FALSE     = 1'b0;
    localparam WORD_TP ZERO_WORD = '0;

    localparam INST_OPT_TP OPT_NONE  = 6'd0;
    localparam INST_OPT_TP OPT_LUI   = 6'd1;
    localparam INST_OPT_TP OPT_AUIPC = 6'd2;
    localparam INST_OPT_TP OPT_JAL   = 6'd3;
    localparam INST_OPT_TP OPT_JALR  = 6'd4;
    localparam INST_OPT_TP OPT_BEQ   = 6'd5;
    localparam INST_OPT_TP OPT_BNE   = 6'd6;
    localparam INST_OPT_TP OPT_BLT   = 6'd7;
    localparam INST_OPT_TP OPT_BGE   = 6'd8;
    localparam INST_OPT_TP OPT_BLTU  = 6'd9;
    localparam INST_OPT_TP OPT_BGEU  = 6'd10;
    localparam INST_OPT_TP OPT_LB    = 6'd11;
    localparam INST_OPT_TP OPT_LH    = 6'd12;
    localparam INST_OPT_TP OPT_LW    = 6'd13;
    localparam INST_OPT_TP OPT_LBU   = 6'd14;
    localparam INST_OPT_TP OPT_LHU   = 6'd15;
    localparam INST_OPT_TP OPT_SB    = 6'd16;
    localparam INST_OPT_TP OPT_SH    = 6'd17;
    localparam INST_OPT_TP OPT_SW    = 6'd18;
    localparam INST_OPT_TP OPT_ADDI  = 6'd19;
    localparam INST_OPT_TP OPT_SLTI  = 6'd20;
    localparam INST_OPT_TP OPT_SLTIU = 6'd21;
    localparam INST_OPT_TP OPT_XORI  = 6'd22;
    localparam INST_OPT_TP OPT_ORI   = 6'd23;
    localparam INST_OPT_TP OPT_ANDI  = 6'd24;
    localparam INST_OPT_TP OPT_SLLI  = 6'd25;
    localparam INST_OPT_TP OPT_SRLI  = 6'd26;
    localparam INST_OPT_TP OPT_SRAI  = 6'd27;
    localparam INST_OPT_TP OPT_ADD   = 6'd28;
    localparam INST_OPT_TP OPT_SUB   = 6'd29;
    localparam INST_OPT_TP OPT_SLL   = 6'd30;
    localparam INST_OPT_TP OPT_SLT   = 6'd31;
    localparam INST_OPT_TP OPT_SLTU  = 6'd32;
    localparam INST_OPT_TP OPT_XOR   = 6'd33;
    localparam INST_OPT_TP OPT_SRL   = 6'd34;
    localparam INST_OPT_TP OPT_SRA   = 6'd35;
    localparam INST_OPT_TP OPT_OR    = 6'd36;
    localparam INST_OPT_TP OPT_AND   = 6'd37;

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-index-set priority encoder: reports whether any request is set and the
// index of the lowest one.
module alu_rs_prio_enc #(
    parameter int unsigned N    = 16,
    parameter int unsigned IDXW = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    output logic            o_found,
    output logic [IDXW-1:0] o_idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU/branch ops until both operands
// resolve via CDB snooping, then issues the lowest-index ready op each cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned RS_SIZE   = 16,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned OPT_W     = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rdy,
    input  logic                 i_flush,

    input  logic                 i_disp_valid,
    input  logic [OPT_W-1:0]     i_disp_opt,
    input  WORD_TP               i_disp_val1,
    input  WORD_TP               i_disp_val2,
    input  logic [ROB_IDX_W-1:0] i_disp_q1,
    input  logic [ROB_IDX_W-1:0] i_disp_q2,
    input  WORD_TP               i_disp_imm,
    input  logic [ROB_IDX_W-1:0] i_disp_rob_idx,
    output logic                 o_rs_full,

    input  logic                 i_cdb_alu_valid,
    input  logic [ROB_IDX_W-1:0] i_cdb_alu_src,
    input  WORD_TP               i_cdb_alu_val,
    input  logic                 i_cdb_lsb_valid,
    input  logic [ROB_IDX_W-1:0] i_cdb_lsb_src,
    input  WORD_TP               i_cdb_lsb_val,

    output logic                 o_rs_valid,
    output logic [OPT_W-1:0]     o_rs_opt,
    output WORD_TP               o_rs_val1,
    output WORD_TP               o_rs_val2,
    output WORD_TP               o_rs_imm,
    output logic [ROB_IDX_W-1:0] o_rs_rob_idx
);

    localparam int unsigned IDXW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   r_busy;
    logic [OPT_W-1:0]     r_opt     [RS_SIZE];
    WORD_TP               r_val1    [RS_SIZE];
    WORD_TP               r_val2    [RS_SIZE];
    logic [ROB_IDX_W-1:0] r_q1      [RS_SIZE];
    logic [ROB_IDX_W-1:0] r_q2      [RS_SIZE];
    WORD_TP               r_imm     [RS_SIZE];
    logic [ROB_IDX_W-1:0] r_rob_idx [RS_SIZE];

    logic [RS_SIZE-1:0]   w_busy;
    logic [OPT_W-1:0]     w_opt     [RS_SIZE];
    WORD_TP               w_val1    [RS_SIZE];
    WORD_TP               w_val2    [RS_SIZE];
    logic [ROB_IDX_W-1:0] w_q1      [RS_SIZE];
    logic [ROB_IDX_W-1:0] w_q2      [RS_SIZE];
    WORD_TP               w_imm     [RS_SIZE];
    logic [ROB_IDX_W-1:0] w_rob_idx [RS_SIZE];

    logic                 r_rs_valid;
    logic [OPT_W-1:0]     r_rs_opt;
    WORD_TP               r_rs_val1;
    WORD_TP               r_rs_val2;
    WORD_TP               r_rs_imm;
    logic [ROB_IDX_W-1:0] r_rs_rob_idx;

    logic                 w_rs_valid;
    logic [OPT_W-1:0]     w_rs_opt;
    WORD_TP               w_rs_val1;
    WORD_TP               w_rs_val2;
    WORD_TP               w_rs_imm;
    logic [ROB_IDX_W-1:0] w_rs_rob_idx;

    logic [RS_SIZE-1:0]   w_free_req;
    logic [RS_SIZE-1:0]   w_ready_req;
    logic                 w_free_found;
    logic [IDXW-1:0]      w_free_idx;
    logic                 w_ready_found;
    logic [IDXW-1:0]      w_ready_idx;

    function automatic logic cdb_hit(input logic                 valid,
                                     input logic [ROB_IDX_W-1:0] src,
                                     input logic [ROB_IDX_W-1:0] q);
        return valid && (src != '0) && (src == q);
    endfunction

    always_comb begin
        w_free_req = ~r_busy;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ready_req[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
        end
    end

    alu_rs_prio_enc #(
        .N    (RS_SIZE),
        .IDXW (IDXW)
    ) u_free_enc (
        .i_req   (w_free_req),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    alu_rs_prio_enc #(
        .N    (RS_SIZE),
        .IDXW (IDXW)
    ) u_ready_enc (
        .i_req   (w_ready_req),
        .o_found (w_ready_found),
        .o_idx   (w_ready_idx)
    );

    always_comb begin
        w_busy       = r_busy;
        w_opt        = r_opt;
        w_val1       = r_val1;
        w_val2       = r_val2;
        w_q1         = r_q1;
        w_q2         = r_q2;
        w_imm        = r_imm;
        w_rob_idx    = r_rob_idx;
        w_rs_valid   = FALSE;
        w_rs_opt     = r_rs_opt;
        w_rs_val1    = r_rs_val1;
        w_rs_val2    = r_rs_val2;
        w_rs_imm     = r_rs_imm;
        w_rs_rob_idx = r_rs_rob_idx;

        if (i_flush) begin
            w_busy = '0;
        end else begin
            // ALU bus is checked first so it wins a (never expected) double match.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    if (cdb_hit(i_cdb_alu_valid, i_cdb_alu_src, r_q1[i])) begin
                        w_val1[i] = i_cdb_alu_val;
                        w_q1[i]   = '0;
                    end else if (cdb_hit(i_cdb_lsb_valid, i_cdb_lsb_src, r_q1[i])) begin
                        w_val1[i] = i_cdb_lsb_val;
                        w_q1[i]   = '0;
                    end
                    if (cdb_hit(i_cdb_alu_valid, i_cdb_alu_src, r_q2[i])) begin
                        w_val2[i] = i_cdb_alu_val;
                        w_q2[i]   = '0;
                    end else if (cdb_hit(i_cdb_lsb_valid, i_cdb_lsb_src, r_q2[i])) begin
                        w_val2[i] = i_cdb_lsb_val;
                        w_q2[i]   = '0;
                    end
                end
            end

            if (w_ready_found) begin
                w_rs_valid            = TRUE;
                w_rs_opt              = r_opt[w_ready_idx];
                w_rs_val1             = r_val1[w_ready_idx];
                w_rs_val2             = r_val2[w_ready_idx];
                w_rs_imm              = r_imm[w_ready_idx];
                w_rs_rob_idx          = r_rob_idx[w_ready_idx];
                w_busy[w_ready_idx]   = FALSE;
            end

            // Free slot comes from registered occupancy, so it never collides with the issued slot.
            if (i_disp_valid && w_free_found) begin
                w_busy[w_free_idx]    = TRUE;
                w_opt[w_free_idx]     = i_disp_opt;
                w_imm[w_free_idx]     = i_disp_imm;
                w_rob_idx[w_free_idx] = i_disp_rob_idx;
                w_val1[w_free_idx]    = i_disp_val1;
                w_q1[w_free_idx]      = i_disp_q1;
                w_val2[w_free_idx]    = i_disp_val2;
                w_q2[w_free_idx]      = i_disp_q2;
                if (cdb_hit(i_cdb_alu_valid, i_cdb_alu_src, i_disp_q1)) begin
                    w_val1[w_free_idx] = i_cdb_alu_val;
                    w_q1[w_free_idx]   = '0;
                end else if (cdb_hit(i_cdb_lsb_valid, i_cdb_lsb_src, i_disp_q1)) begin
                    w_val1[w_free_idx] = i_cdb_lsb_val;
                    w_q1[w_free_idx]   = '0;
                end
                if (cdb_hit(i_cdb_alu_valid, i_cdb_alu_src, i_disp_q2)) begin
                    w_val2[w_free_idx] = i_cdb_alu_val;
                    w_q2[w_free_idx]   = '0;
                end else if (cdb_hit(i_cdb_lsb_valid, i_cdb_lsb_src, i_disp_q2)) begin
                    w_val2[w_free_idx] = i_cdb_lsb_val;
                    w_q2[w_free_idx]   = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_busy       <= '0;
            r_rs_valid   <= FALSE;
            r_rs_opt     <= '0;
            r_rs_val1    <= ZERO_WORD;
            r_rs_val2    <= ZERO_WORD;
            r_rs_imm     <= ZERO_WORD;
            r_rs_rob_idx <= '0;
        end else if (i_rdy) begin
            r_busy       <= w_busy;
            r_rs_valid   <= w_rs_valid;
            r_rs_opt     <= w_rs_opt;
            r_rs_val1    <= w_rs_val1;
            r_rs_val2    <= w_rs_val2;
            r_rs_imm     <= w_rs_imm;
            r_rs_rob_idx <= w_rs_rob_idx;
        end
    end

    // Entry payload is only meaningful under busy, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (i_rst && i_rdy) begin
            r_opt     <= w_opt;
            r_val1    <= w_val1;
            r_val2    <= w_val2;
            r_q1      <= w_q1;
            r_q2      <= w_q2;
            r_imm     <= w_imm;
            r_rob_idx <= w_rob_idx;
        end
    end

    assign o_rs_full    = &r_busy;
    assign o_rs_valid   = r_rs_valid;
    assign o_rs_opt     = r_rs_opt;
    assign o_rs_val1    = r_rs_val1;
    assign o_rs_val2    = r_rs_val2;
    assign o_rs_imm     = r_rs_imm;
    assign o_rs_rob_idx = r_rs_rob_idx;

endmodule
